// File: rtl/shared_ins_mem_pkg.sv
// Shared processor defaults for the instruction memory and its read arbiter.
package shared_ins_mem_pkg;

   localparam int DEF_DATA_WIDTH = 12;
   localparam int DEF_DEPTH      = 256;
   localparam int DEF_CORE_COUNT = 4;

   // Index width that stays legal (>= 1 bit) for a single core.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shared_ins_mem_rr_arbiter.sv
// Round-robin grant for the core read ports; the grant is combinational and the
// last-grant pointer is registered. A blocked cycle (write or reset) issues no grant.
module rr_arbiter
   import shared_ins_mem_pkg::*;
#(
   parameter int CORE_COUNT = DEF_CORE_COUNT,
   parameter int IDX_WIDTH  = idx_width(CORE_COUNT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CORE_COUNT-1:0] req,
   input  logic                  blk,
   output logic [CORE_COUNT-1:0] gnt,
   output logic [IDX_WIDTH-1:0]  last_gnt
);

   logic [IDX_WIDTH-1:0] last_gnt_d, last_gnt_q;
   logic [IDX_WIDTH-1:0] cand;
   logic                 found;

   // Search starts one past the last winner; modulo keeps the wrap correct for any count.
   always_comb begin
      gnt        = '0;
      last_gnt_d = last_gnt_q;
      found      = 1'b0;
      cand       = '0;
      for (int k = 1; k <= CORE_COUNT; k++) begin
         cand = IDX_WIDTH'((int'(last_gnt_q) + k) % CORE_COUNT);
         if (!found && !blk && req[cand]) begin
            found      = 1'b1;
            gnt[cand]  = 1'b1;
            last_gnt_d = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_gnt_q <= IDX_WIDTH'(CORE_COUNT - 1);
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end

   assign last_gnt = last_gnt_q;

endmodule

// File: rtl/shared_ins_mem.sv
// Single-port instruction RAM shared by CORE_COUNT read ports; loader writes win the port,
// reads are round-robin arbitrated and return one cycle after grant with a per-core valid pulse.
module shared_ins_mem
   import shared_ins_mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int CORE_COUNT = DEF_CORE_COUNT,
   parameter int IDX_WIDTH  = idx_width(CORE_COUNT)
) (
   input  logic                             clk,
   input  logic                             rstN,
   input  logic                             wrEn,
   input  logic [ADDR_WIDTH-1:0]            wrAddr,
   input  logic [DATA_WIDTH-1:0]            dataIn,
   input  logic [CORE_COUNT-1:0]            rdReq,
   input  logic [CORE_COUNT*ADDR_WIDTH-1:0] rdAddr,
   output logic [CORE_COUNT-1:0]            rdGnt,
   output logic [CORE_COUNT-1:0]            rdValid,
   output logic [CORE_COUNT*DATA_WIDTH-1:0] rdData,
   output logic [IDX_WIDTH-1:0]             lastGnt
);

   logic                                 arb_blk;
   logic [CORE_COUNT-1:0]                gnt;
   logic [ADDR_WIDTH-1:0]                acc_addr;
   logic [DATA_WIDTH-1:0]                mem [DEPTH];
   logic [DATA_WIDTH-1:0]                ram_rd_q;
   logic [CORE_COUNT-1:0]                rd_vld_d, rd_vld_q;
   logic [CORE_COUNT-1:0][DATA_WIDTH-1:0] rd_dat_d, rd_dat_q;

   assign arb_blk = wrEn | ~rstN;

   rr_arbiter #(
      .CORE_COUNT (CORE_COUNT),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_arb (
      .clk      (clk),
      .rst_n    (rstN),
      .req      (rdReq),
      .blk      (arb_blk),
      .gnt      (gnt),
      .last_gnt (lastGnt)
   );

   // One address for the single port: the write address, else the granted core's address.
   always_comb begin
      acc_addr = wrAddr;
      for (int i = 0; i < CORE_COUNT; i++) begin
         if (gnt[i]) acc_addr = rdAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rstN && wrEn) begin
         mem[acc_addr] <= dataIn;
      end else if (|gnt) begin
         ram_rd_q <= mem[acc_addr];
      end
   end

   // The RAM output register feeds only the slice whose valid is up; others hold.
   always_comb begin
      rd_vld_d = gnt;
      rd_dat_d = rd_dat_q;
      for (int i = 0; i < CORE_COUNT; i++) begin
         if (rd_vld_q[i]) rd_dat_d[i] = ram_rd_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         rd_vld_q <= '0;
         rd_dat_q <= '0;
      end else begin
         rd_vld_q <= rd_vld_d;
         rd_dat_q <= rd_dat_d;
      end
   end

   assign rdGnt   = gnt;
   assign rdValid = rd_vld_q;
   assign rdData  = rd_dat_d;

endmodule
